sm83_mem_if: RTL and testbench

SM83_MEM_IF -- requirements
Module: sm83_mem_if

---
 rtl/sm83_mem_if.sv | 97 +++++++++
 tb/tb_sm83_mem_if.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sm83_mem_if.sv
// SM83 memory-cycle sequencer: turns rd/wr requests into T1..T4 bus M-cycles.
// Optional wait-state stalling in T3 is enabled by defining SM83_MEM_WAIT_EN.
module sm83_mem_if #(
    parameter int unsigned ADR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADR_WIDTH-1:0] adr,
    input  logic                 rd_req,
    input  logic                 wr_req,
    input  logic [7:0]           wdata,
    output logic                 req_ack,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           rdata,
    output logic [ADR_WIDTH-1:0] ext_adr,
    output logic [7:0]           ext_dout,
    input  logic [7:0]           ext_din,
    output logic                 ext_rd,
    output logic                 ext_wr,
    input  logic                 ext_wait
);

    typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4} state_e;

    state_e                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [7:0]             rdata_q, rdata_d;
    logic                   op_wr_q, op_wr_d;
    logic                   stall;

`ifdef SM83_MEM_WAIT_EN
    assign stall = ext_wait;
`else
    logic unused_ext_wait;
    assign unused_ext_wait = ext_wait;
    assign stall           = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_wr_d = op_wr_q;
        req_ack = !reset && (state_q == StIdle || state_q == StT4) && (rd_req || wr_req);

        unique case (state_q)
            StT1: state_d = StT2;
            StT2: state_d = StT3;
            StT3: begin
                if (!stall) begin
                    state_d = StT4;
                    if (!op_wr_q) rdata_d = ext_din;
                end
            end
            default: state_d = StIdle;  // StIdle and StT4 without a new request
        endcase

        // Write wins when both requests are present.
        if (req_ack) begin
            state_d = StT1;
            adr_d   = adr;
            wdata_d = wdata;
            op_wr_d = wr_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_wr_q <= op_wr_d;
        end
    end

    always_comb begin
        busy     = (state_q != StIdle);
        // A reset landing in T4 aborts the access, so no done pulse.
        done     = (state_q == StT4) && !reset;
        rdata    = rdata_q;
        ext_adr  = adr_q;
        ext_dout = (busy && op_wr_q) ? wdata_q : 8'h00;
        ext_rd   = !op_wr_q && (state_q == StT1 || state_q == StT2 || state_q == StT3);
        ext_wr   = op_wr_q && (state_q == StT2 || state_q == StT3);
    end

endmodule

// File: tb/tb_sm83_mem_if.sv
// Self-checking bench for sm83_mem_if: directed scenarios plus random traffic,
// all compared against a cycle-timeline reference model of the M-cycle.
module tb_sm83_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic        rd_req, wr_req;
    logic [7:0]  wdata;
    logic        req_ack, busy, done;
    logic [7:0]  rdata;
    logic [15:0] ext_adr;
    logic [7:0]  ext_dout;
    logic [7:0]  ext_din;
    logic        ext_rd, ext_wr;
    logic        ext_wait;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: position within the current access (0 = no access).
    int          m_k      = 0;
    logic        m_wr     = 1'b0;
    logic [15:0] m_adr    = '0;
    logic [7:0]  m_wdata  = '0;
    logic [7:0]  m_rdata  = '0;
    logic        last_busy;

    always #5 clk = ~clk;

    sm83_mem_if #(.ADR_WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .adr      (adr),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .wdata    (wdata),
        .req_ack  (req_ack),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .ext_adr  (ext_adr),
        .ext_dout (ext_dout),
        .ext_din  (ext_din),
        .ext_rd   (ext_rd),
        .ext_wr   (ext_wr),
        .ext_wait (ext_wait)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic step(input logic rst, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] wd, input logic [7:0] din, input logic wt);
        logic ack_exp, stall;
        reset = rst; rd_req = rd; wr_req = wr; adr = a; wdata = wd;
        ext_din = din; ext_wait = wt;
        ack_exp = !rst && (m_k == 0 || m_k == 4) && (rd || wr);
`ifdef SM83_MEM_WAIT_EN
        stall = wt;
`else
        stall = 1'b0;
`endif
        @(negedge clk);
        check_val("req_ack", req_ack, ack_exp);
        check_val("busy", busy, m_k != 0);
        check_val("done", done, m_k == 4 && !rst);
        check_val("ext_rd", ext_rd, !m_wr && m_k >= 1 && m_k <= 3);
        check_val("ext_wr", ext_wr, m_wr && m_k >= 2 && m_k <= 3);
        check_val("ext_adr", ext_adr, m_adr);
        check_val("ext_dout", ext_dout, (m_k != 0 && m_wr) ? m_wdata : 8'h00);
        check_val("rdata", rdata, m_rdata);
        last_busy = busy;
        @(posedge clk);
        if (rst) begin
            m_k = 0; m_wr = 1'b0; m_adr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            if (m_k == 3 && !stall && !m_wr) m_rdata = din;
            if (ack_exp) begin
                m_k = 1; m_adr = a; m_wdata = wd; m_wr = wr;
            end else if (m_k == 4) m_k = 0;
            else if (m_k == 3 && stall) m_k = 3;
            else if (m_k != 0) m_k++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 1'b0);
    endtask

    initial begin
        int cnt;
        logic rq, r, w;
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; adr = '0; wdata = '0;
        ext_din = '0; ext_wait = 1'b0;
        @(posedge clk); #1;
        // Reset state, including a request that reset must dominate.
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, 8'h11, 8'h22, 1'b0);
        idle(2);

        // Read 0x1234 returning 0x5A.
        step(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h5A, 1'b0);
        check_val("read_rdata", rdata, 8'h5A);

        // Write 0xA7 to 0xC000; rdata must keep 0x5A.
        step(1'b0, 1'b0, 1'b1, 16'hC000, 8'hA7, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h99, 1'b0);
        check_val("write_keeps_rdata", rdata, 8'h5A);

        // Back-to-back reads with rd_req held: 8 busy clocks, no idle gap.
        cnt = 0;
        step(1'b0, 1'b1, 1'b0, 16'h0100, 8'h0, 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0101, 8'h0, 8'h01, 1'b0);
            cnt += int'(last_busy);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h02, 1'b0);
            cnt += int'(last_busy);
        end
        check_val("b2b_busy_clocks", cnt, 8);

        // Simultaneous requests: write wins.
        step(1'b0, 1'b1, 1'b1, 16'hFF80, 8'h3C, 8'h00, 1'b0);
        idle(5);

        // Wait states: ext_wait high for the first three T3 samples.
        cnt = 0;
        step(1'b0, 1'b1, 1'b0, 16'h2000, 8'h0, 8'h00, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'(8'h40 + i), (i >= 3 && i <= 5));
            cnt += int'(last_busy);
        end
`ifdef SM83_MEM_WAIT_EN
        check_val("wait_clocks", cnt, 7);
`else
        check_val("wait_clocks", cnt, 4);
`endif

        // Reset in T2 of a read.
        step(1'b0, 1'b1, 1'b0, 16'h3000, 8'h0, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 8'hEE, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'hEE, 1'b0);
        idle(1);
        check_val("reset_abort_busy", last_busy, 1'b0);
        check_val("reset_abort_rdata", rdata, 8'h00);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rq = ($urandom_range(0, 1) == 1);
            r  = rq ? 1'($urandom) : 1'b0;
            w  = rq ? 1'($urandom) : 1'b0;
            if ((m_k == 0 || m_k == 4) && rq && !r && !w) r = 1'b1;
            step(($urandom_range(0, 63) == 0), r, w, 16'($urandom), 8'($urandom),
                 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
